// File: rtl/trng_harvest_ctrl.sv
// trng_harvest_ctrl: sequences the ring-oscillator TRNG array.
// The controller enables the array and waits out a warm-up interval.
// It then captures raw words at a programmable rate and runs a
// repetition-count health test on each one. Words that pass go out on a
// valid/ready stream, tagged with a round-robin Fortuna pool index.
module trng_harvest_ctrl #(
  parameter int WARMUP_CYCLES = 64,
  parameter int SAMPLE_DIV    = 8,
  parameter int REP_LIMIT     = 4,
  parameter int NUM_POOLS     = 32,
  localparam int POOL_W       = (NUM_POOLS > 1) ? $clog2(NUM_POOLS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              clear_fault,
  input  logic [31:0]       trng_r,
  output logic              trng_en,
  output logic [31:0]       out_data,
  output logic [POOL_W-1:0] out_pool,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              fault
);

  // One down-counter serves both the warm-up interval and the sample divider.
  // The two intervals never overlap, so a shared counter is enough.
  localparam int MAX_CNT = (WARMUP_CYCLES > SAMPLE_DIV) ? WARMUP_CYCLES : SAMPLE_DIV;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int REP_W   = $clog2(REP_LIMIT + 1);

  localparam logic [CNT_W-1:0]  WARM_LOAD = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DIV_LOAD  = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [POOL_W-1:0] POOL_LAST = POOL_W'(NUM_POOLS - 1);
  localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REP_LIMIT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WARMUP = 3'd1,
    SAMPLE = 3'd2,
    HOLD   = 3'd3,
    FAULT  = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [REP_W-1:0]  rep_reg, rep_next;
  logic [31:0]       prev_reg, prev_next;
  logic              prev_valid_reg, prev_valid_next;
  logic [31:0]       data_reg, data_next;
  logic [POOL_W-1:0] pool_reg, pool_next;
  logic              en_reg, valid_reg, busy_reg, fault_reg;
  logic              en_next, valid_next, busy_next, fault_next;
  logic [REP_W-1:0]  rep_new;
  logic              handshake;

  assign trng_en   = en_reg;
  assign out_data  = data_reg;
  assign out_pool  = pool_reg;
  assign out_valid = valid_reg;
  assign busy      = busy_reg;
  assign fault     = fault_reg;

  // Next-state, datapath and output decode; outputs are decoded from the
  // next state so that, once registered, they track the state register.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    rep_next        = rep_reg;
    prev_next       = prev_reg;
    prev_valid_next = prev_valid_reg;
    data_next       = data_reg;
    pool_next       = pool_reg;
    handshake       = (state_reg == HOLD) && out_ready;
    rep_new         = (prev_valid_reg && (trng_r == prev_reg)) ? rep_reg + REP_W'(1) : REP_W'(1);

    unique case (state_reg)
      IDLE: begin
        prev_valid_next = 1'b0;
        if (run) begin
          state_next = WARMUP;
          cnt_next   = WARM_LOAD;
        end
      end
      WARMUP: begin
        if (!run) begin
          state_next      = IDLE;
          prev_valid_next = 1'b0;
        end else if (cnt_reg == '0) begin
          state_next = SAMPLE;
          cnt_next   = DIV_LOAD;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      SAMPLE: begin
        if (!run) begin
          state_next      = IDLE;
          prev_valid_next = 1'b0;
        end else if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          rep_next        = rep_new;
          prev_next       = trng_r;
          prev_valid_next = 1'b1;
          if (rep_new == REP_MAX) begin
            // A stuck source: discard the word and keep out_data unchanged.
            state_next = FAULT;
          end else begin
            data_next  = trng_r;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        // A presented word is never dropped; run=0 only takes effect once
        // the consumer has accepted it.
        if (handshake) begin
          pool_next = (pool_reg == POOL_LAST) ? '0 : pool_reg + POOL_W'(1);
          if (run) begin
            state_next = SAMPLE;
            cnt_next   = DIV_LOAD;
          end else begin
            state_next      = IDLE;
            prev_valid_next = 1'b0;
          end
        end
      end
      FAULT: begin
        if (clear_fault) begin
          state_next      = IDLE;
          rep_next        = '0;
          prev_valid_next = 1'b0;
        end
      end
      default: begin
        state_next      = IDLE;
        prev_valid_next = 1'b0;
      end
    endcase

    en_next    = (state_next == WARMUP) || (state_next == SAMPLE) || (state_next == HOLD);
    valid_next = (state_next == HOLD);
    fault_next = (state_next == FAULT);
    busy_next  = (state_next != IDLE);
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      rep_reg        <= '0;
      prev_reg       <= '0;
      prev_valid_reg <= 1'b0;
      data_reg       <= '0;
      pool_reg       <= '0;
      en_reg         <= 1'b0;
      valid_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      rep_reg        <= rep_next;
      prev_reg       <= prev_next;
      prev_valid_reg <= prev_valid_next;
      data_reg       <= data_next;
      pool_reg       <= pool_next;
      en_reg         <= en_next;
      valid_reg      <= valid_next;
      busy_reg       <= busy_next;
      fault_reg      <= fault_next;
    end
  end

endmodule
